// File: rtl/sap1_pkg.sv
// SAP-1 control sequencer package: widths, opcodes, control-word bit map,
// named control words and one-hot T-state encodings.
package sap1_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned CW_W  = 12;
  localparam int unsigned NUM_T = 6;

  // Opcodes (IR upper nibble)
  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  // Control-word bit positions {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam int unsigned CW_CP = 11;
  localparam int unsigned CW_EP = 10;
  localparam int unsigned CW_LM = 9;
  localparam int unsigned CW_CE = 8;   // active-low
  localparam int unsigned CW_LI = 7;
  localparam int unsigned CW_EI = 6;   // active-low
  localparam int unsigned CW_LA = 5;
  localparam int unsigned CW_EA = 4;
  localparam int unsigned CW_SU = 3;
  localparam int unsigned CW_EU = 2;
  localparam int unsigned CW_LB = 1;
  localparam int unsigned CW_LO = 0;

  // Named control words; CE and Ei stay high unless the step drives them
  localparam logic [CW_W-1:0] CW_IDLE   = 12'h140;
  localparam logic [CW_W-1:0] CW_T1     = 12'h740;  // Ep, Lm
  localparam logic [CW_W-1:0] CW_T2     = 12'h940;  // Cp
  localparam logic [CW_W-1:0] CW_T3     = 12'h0C0;  // CE low, Li
  localparam logic [CW_W-1:0] CW_LDA_T4 = 12'h300;  // Ei low, Lm
  localparam logic [CW_W-1:0] CW_LDA_T5 = 12'h060;  // CE low, La
  localparam logic [CW_W-1:0] CW_ADD_T4 = 12'h300;  // Ei low, Lm
  localparam logic [CW_W-1:0] CW_ADD_T5 = 12'h042;  // CE low, Lb
  localparam logic [CW_W-1:0] CW_ADD_T6 = 12'h164;  // Eu, La
  localparam logic [CW_W-1:0] CW_SUB_T6 = 12'h16C;  // Su, Eu, La
  localparam logic [CW_W-1:0] CW_OUT_T4 = 12'h151;  // Ea, Lo

  // One-hot T-states, T1 = bit 0
  localparam logic [NUM_T-1:0] T1_OH = 6'b000001;
  localparam logic [NUM_T-1:0] T2_OH = 6'b000010;
  localparam logic [NUM_T-1:0] T3_OH = 6'b000100;
  localparam logic [NUM_T-1:0] T4_OH = 6'b001000;
  localparam logic [NUM_T-1:0] T5_OH = 6'b010000;
  localparam logic [NUM_T-1:0] T6_OH = 6'b100000;

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// Sequencer <-> datapath bundle. master = sequencer, slave = datapath.
// Optional SAP1_STEP_EN adds the single-step button input.
interface sap1_control_sequencer_if;
  import sap1_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic [CW_W-1:0]  con_word;
  logic [NUM_T-1:0] t_state;
  logic             halted;
  logic             instr_done;
`ifdef SAP1_STEP_EN
  logic             step;
`endif

  modport master (
    input  opcode,
`ifdef SAP1_STEP_EN
    input  step,
`endif
    output con_word,
    output t_state,
    output halted,
    output instr_done
  );

  modport slave (
    output opcode,
`ifdef SAP1_STEP_EN
    output step,
`endif
    input  con_word,
    input  t_state,
    input  halted,
    input  instr_done
  );

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter. With WaitEn set, an all-zero WAIT state sits
// between T6 and T1 and is left only when start is high.
module sap1_ring_counter
  import sap1_pkg::*;
#(
  parameter bit WaitEn = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             hold,
  input  logic             start,
  output logic [NUM_T-1:0] t_state
);

  localparam logic [NUM_T-1:0] ResetVal = WaitEn ? '0 : T1_OH;
  localparam logic [NUM_T-1:0] WrapVal  = WaitEn ? '0 : T1_OH;

  logic [NUM_T-1:0] t_q, t_d;

  // Next state: hold, leave WAIT on start, wrap after T6, else shift
  always_comb begin
    t_d = t_q;
    if (hold) begin
      t_d = t_q;
    end else if (t_q == '0) begin
      t_d = start ? T1_OH : '0;
    end else if (t_q[NUM_T-1]) begin
      t_d = WrapVal;
    end else begin
      t_d = {t_q[NUM_T-2:0], 1'b0};
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) t_q <= ResetVal;
    else     t_q <= t_d;
  end

  assign t_state = t_q;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: ring counter plus combinational opcode/T-state
// decode into the 12-bit control word. Define SAP1_STEP_EN for single-step
// operation (WAIT state between instructions, released by a step edge).
module sap1_control_sequencer
  import sap1_pkg::*;
(
  input logic                     CLK,
  input logic                     CLR,
  sap1_control_sequencer_if.master bus
);

  logic [NUM_T-1:0] t_state;
  logic             halted_q;
  logic             start;

`ifdef SAP1_STEP_EN
  logic step_meta_q, step_sync_q, step_prev_q;

  // Synchronise the step button and keep the previous value for edge detect
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_meta_q <= bus.step;
      step_sync_q <= step_meta_q;
      step_prev_q <= step_sync_q;
    end
  end

  // Only sampled by the counter while in WAIT, so edges mid-instruction drop
  assign start = step_sync_q & ~step_prev_q;
  localparam bit WaitEn = 1'b1;
`else
  assign start = 1'b1;
  localparam bit WaitEn = 1'b0;
`endif

  sap1_ring_counter #(
    .WaitEn (WaitEn)
  ) u_ring (
    .clk     (CLK),
    .clr     (CLR),
    .hold    (halted_q),
    .start   (start),
    .t_state (t_state)
  );

  // Halt latches at the end of T4 of HLT; the counter has just moved to T5
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      halted_q <= 1'b0;
    end else if (t_state == T4_OH && bus.opcode == OP_HLT) begin
      halted_q <= 1'b1;
    end
  end

  // Control-word decode from current T-state and opcode
  always_comb begin
    bus.con_word = CW_IDLE;
    if (!CLR && !halted_q) begin
      unique case (t_state)
        T1_OH: bus.con_word = CW_T1;
        T2_OH: bus.con_word = CW_T2;
        T3_OH: bus.con_word = CW_T3;
        T4_OH: begin
          case (bus.opcode)
            OP_LDA:  bus.con_word = CW_LDA_T4;
            OP_ADD,
            OP_SUB:  bus.con_word = CW_ADD_T4;
            OP_OUT:  bus.con_word = CW_OUT_T4;
            default: bus.con_word = CW_IDLE;
          endcase
        end
        T5_OH: begin
          case (bus.opcode)
            OP_LDA:  bus.con_word = CW_LDA_T5;
            OP_ADD,
            OP_SUB:  bus.con_word = CW_ADD_T5;
            default: bus.con_word = CW_IDLE;
          endcase
        end
        T6_OH: begin
          case (bus.opcode)
            OP_ADD:  bus.con_word = CW_ADD_T6;
            OP_SUB:  bus.con_word = CW_SUB_T6;
            default: bus.con_word = CW_IDLE;
          endcase
        end
        default: bus.con_word = CW_IDLE;
      endcase
    end
  end

  // Status outputs; HLT freezes in T5 so it never reaches the T6 pulse
  always_comb begin
    bus.t_state    = t_state;
    bus.halted     = halted_q;
    bus.instr_done = (t_state == T6_OH) && !halted_q && !CLR;
  end

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed bench for sap1_control_sequencer (default and SAP1_STEP_EN builds).
module tb_sap1_control_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  sap1_control_sequencer_if bus ();

  sap1_control_sequencer dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting in T1; opcode is junk during T1-T2
  task automatic run_instr(input logic [3:0] op, input logic [11:0] w4, input logic [11:0] w5,
                           input logic [11:0] w6);
    bus.opcode = op ^ 4'h5;
    check("t1_cw", {20'd0, bus.con_word}, 32'h740);
    check("t1_ts", {26'd0, bus.t_state}, 32'h01);
    check("t1_done", {31'd0, bus.instr_done}, 32'd0);
    tick();
    bus.opcode = ~op;
    check("t2_cw", {20'd0, bus.con_word}, 32'h940);
    tick();
    check("t3_cw", {20'd0, bus.con_word}, 32'h0C0);
    bus.opcode = op;
    tick();
    check("t4_cw", {20'd0, bus.con_word}, {20'd0, w4});
    check("t4_ts", {26'd0, bus.t_state}, 32'h08);
    tick();
    check("t5_cw", {20'd0, bus.con_word}, {20'd0, w5});
    check("t5_done", {31'd0, bus.instr_done}, 32'd0);
    tick();
    check("t6_cw", {20'd0, bus.con_word}, {20'd0, w6});
    check("t6_ts", {26'd0, bus.t_state}, 32'h20);
    check("t6_done", {31'd0, bus.instr_done}, 32'd1);
    tick();
  endtask

  initial begin
    bus.opcode = 4'h0;
`ifdef SAP1_STEP_EN
    bus.step = 1'b0;
`endif
    tick();
    tick();
    check("rst_cw", {20'd0, bus.con_word}, 32'h140);
    check("rst_halt", {31'd0, bus.halted}, 32'd0);
    check("rst_done", {31'd0, bus.instr_done}, 32'd0);
`ifndef SAP1_STEP_EN
    check("rst_ts", {26'd0, bus.t_state}, 32'h01);
    clr = 1'b0;
    #1;
    run_instr(4'h0, 12'h300, 12'h060, 12'h140);   // LDA
    run_instr(4'h1, 12'h300, 12'h042, 12'h164);   // ADD
    run_instr(4'h2, 12'h300, 12'h042, 12'h16C);   // SUB
    run_instr(4'hE, 12'h151, 12'h140, 12'h140);   // OUT
    run_instr(4'h7, 12'h140, 12'h140, 12'h140);   // undefined -> NOP
    run_instr(4'h0, 12'h300, 12'h060, 12'h140);   // next T1 after NOP is a fetch

    // CLR asserted mid-T4 forces IDLE and T1 immediately
    tick(); tick(); tick();
    check("pre_clr_t4", {20'd0, bus.con_word}, 32'h300);
    clr = 1'b1;
    #1;
    check("clr_mid_cw", {20'd0, bus.con_word}, 32'h140);
    check("clr_mid_ts", {26'd0, bus.t_state}, 32'h01);
    tick();
    clr = 1'b0;
    #1;

    // HLT
    bus.opcode = 4'hF;
    check("hlt_t1", {20'd0, bus.con_word}, 32'h740);
    tick(); tick(); tick();
    check("hlt_t4_cw", {20'd0, bus.con_word}, 32'h140);
    check("hlt_t4_halt", {31'd0, bus.halted}, 32'd0);
    tick();
    check("hlt_set", {31'd0, bus.halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("hlt_cw", {20'd0, bus.con_word}, 32'h140);
      check("hlt_ts", {26'd0, bus.t_state}, 32'h10);
      check("hlt_done", {31'd0, bus.instr_done}, 32'd0);
      tick();
    end

    // CLR restarts from T1
    clr = 1'b1;
    #1;
    check("unhalt", {31'd0, bus.halted}, 32'd0);
    tick();
    clr = 1'b0;
    #1;
    run_instr(4'h1, 12'h300, 12'h042, 12'h164);
`else
    check("rst_ts", {26'd0, bus.t_state}, 32'h00);
    clr = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      check("wait_cw", {20'd0, bus.con_word}, 32'h140);
      check("wait_ts", {26'd0, bus.t_state}, 32'h00);
      tick();
    end
    bus.step = 1'b1;
    begin : wait_t1
      for (int i = 0; i < 10; i++) begin
        if (bus.t_state == 6'b000001) disable wait_t1;
        tick();
      end
    end
    check("step_t1_ts", {26'd0, bus.t_state}, 32'h01);
    bus.step = 1'b0;
    bus.opcode = 4'h0;
    check("step_t1_cw", {20'd0, bus.con_word}, 32'h740);
    tick();
    check("step_t2_cw", {20'd0, bus.con_word}, 32'h940);
    tick();
    bus.step = 1'b1;   // ignored mid-instruction
    check("step_t3_cw", {20'd0, bus.con_word}, 32'h0C0);
    tick();
    check("step_t4_cw", {20'd0, bus.con_word}, 32'h300);
    tick();
    bus.step = 1'b0;
    check("step_t5_cw", {20'd0, bus.con_word}, 32'h060);
    tick();
    check("step_t6_done", {31'd0, bus.instr_done}, 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("back_wait_ts", {26'd0, bus.t_state}, 32'h00);
      tick();
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
